// File: rtl/clk_freq_meter_pkg.sv
// ============================================================================
// Module : clk_freq_meter_pkg
// Brief  : Helper for sizing counters in the frequency meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clk_freq_meter_pkg;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Single-bit two-flop synchronizer, asynchronous active-high reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/clk_freq_meter.sv
// ============================================================================
// Module : clk_freq_meter
// Brief  : Counts rising edges of meas_clk over a GATE_CYCLES-long clk window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             meas_clk,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic             busy
);

    localparam int           GW          = cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0] c_gate_last = GW'(GATE_CYCLES - 1);
    localparam logic [0:0]   c_st_idle   = 1'b0;
    localparam logic [0:0]   c_st_gate   = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_sticky;
    logic             w_meas_sync;
    logic             r_meas_prev;
    logic             w_edge;
    logic             w_last;
    logic             w_cnt_full;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (meas_clk),
        .q   (w_meas_sync)
    );

    assign w_edge     = w_meas_sync & ~r_meas_prev;
    assign w_last     = (r_state == c_st_gate) && (r_gate_cnt == c_gate_last);
    assign w_cnt_full = &r_edge_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (en) w_next_state = c_st_gate;
            c_st_gate: if (!en) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_gate);
    end

    // Counters run only in non-final GATE cycles with en high; every other
    // case (idle, abort, window boundary) restarts them from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meas_prev  <= 1'b0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_meas_prev <= w_meas_sync;
            if ((r_state == c_st_gate) && en && !w_last) begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
                if (w_edge) begin
                    if (w_cnt_full) begin
                        r_ovf_sticky <= 1'b1;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                    end
                end
            end else begin
                r_gate_cnt   <= '0;
                r_edge_cnt   <= '0;
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    // The final cycle's own edge belongs to the window being published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq       <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else begin
            freq_valid <= w_last;
            if (w_last) begin
                freq     <= w_cnt_full ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);
                freq_ovf <= r_ovf_sticky | (w_edge & w_cnt_full);
            end
        end
    end

endmodule

`default_nettype wire
